led_pwm_monitor: RTL and testbench

Receive-side companion to the breathing-LED drivers: observes the 8-bit one-hot PWM LED bus and recovers, per PWM frame, the active LED index, the measured duty (high cycles per frame) and the breathing trend (rising / falling / flat). It sits beside any LED mode driver on the same `clk`, and is used for self-check in hardware and as a scoreboard front-end in simulation.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_trend_fsm.sv | 63 ++++++
 rtl/led_pwm_monitor.sv | 78 +++++++
 tb/tb_led_pwm_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the breathing-LED drivers and the PWM monitor:
// frame length, LED bus width, trend encoding and a one-hot index helper.
package led_pkg;

  localparam int LED_PWM_PERIOD = 6;
  localparam int LED_W          = 8;

  localparam logic [1:0] TREND_FLAT = 2'b00;
  localparam logic [1:0] TREND_RISE = 2'b01;
  localparam logic [1:0] TREND_FALL = 2'b10;

  typedef enum logic [1:0] {
    ST_FLAT = TREND_FLAT,
    ST_RISE = TREND_RISE,
    ST_FALL = TREND_FALL
  } trend_state_e;

  // Only meaningful for a one-hot input; callers gate the result.
  function automatic logic [2:0] onehot_index(input logic [LED_W-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < LED_W; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_trend_fsm.sv
// Breathing-trend tracker: compares each frame's duty with the previous one
// and settles to FLAT after HOLD_FRAMES consecutive equal frames.
module led_trend_fsm
  import led_pkg::*;
#(
  parameter int HOLD_FRAMES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid_int,
  input  logic [CNT_W-1:0] duty_meas,
  output logic [1:0]       trend
);

  localparam int EQ_W = $clog2(HOLD_FRAMES + 1);

  trend_state_e     state, state_nxt;
  logic [CNT_W-1:0] prev_duty, prev_duty_nxt;
  logic [EQ_W-1:0]  eq_cnt, eq_cnt_nxt;
  logic             have_prev, have_prev_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FLAT;
      prev_duty <= '0;
      eq_cnt    <= '0;
      have_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_duty <= prev_duty_nxt;
      eq_cnt    <= eq_cnt_nxt;
      have_prev <= have_prev_nxt;
    end
  end

  // The very first frame after reset has nothing to compare against, so it only seeds prev_duty.
  always_comb begin
    state_nxt     = state;
    prev_duty_nxt = prev_duty;
    eq_cnt_nxt    = eq_cnt;
    have_prev_nxt = have_prev;
    if (frame_valid_int) begin
      prev_duty_nxt = duty_meas;
      have_prev_nxt = 1'b1;
      if (have_prev) begin
        if (duty_meas > prev_duty) begin
          state_nxt  = ST_RISE;
          eq_cnt_nxt = '0;
        end else if (duty_meas < prev_duty) begin
          state_nxt  = ST_FALL;
          eq_cnt_nxt = '0;
        end else begin
          if (eq_cnt < EQ_W'(HOLD_FRAMES)) eq_cnt_nxt = eq_cnt + 1'b1;
          if (eq_cnt_nxt == EQ_W'(HOLD_FRAMES)) state_nxt = ST_FLAT;
        end
      end
    end
  end

  assign trend = state;

endmodule

// File: rtl/led_pwm_monitor.sv
// Observes the one-hot PWM LED bus and reports, once per frame, the duty,
// the active LED index, multi-hot errors and the breathing trend.
module led_pwm_monitor
  import led_pkg::*;
#(
  parameter int PERIOD      = LED_PWM_PERIOD,
  parameter int HOLD_FRAMES = 4,
  parameter int CNT_W       = $clog2(PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] led_in,
  output logic             frame_valid,
  output logic [CNT_W-1:0] duty_meas,
  output logic [2:0]       led_idx,
  output logic             idx_changed,
  output logic             err_multi,
  output logic [1:0]       trend
);

  logic [CNT_W-1:0] win_cnt, acc, duty_now;
  logic [2:0]       idx_nxt, idx_now;
  logic             multi_nxt, first_done;
  logic             sample_hot, sample_multi, sample_onehot, frame_end;

  // v & (v-1) clears the lowest set bit, so anything left means two or more bits.
  assign sample_hot    = |led_in;
  assign sample_multi  = |(led_in & (led_in - LED_W'(1)));
  assign sample_onehot = sample_hot & ~sample_multi;
  assign idx_now       = sample_onehot ? onehot_index(led_in) : idx_nxt;
  assign duty_now      = acc + CNT_W'(sample_hot);
  assign frame_end     = (win_cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      acc         <= '0;
      idx_nxt     <= '0;
      multi_nxt   <= 1'b0;
      first_done  <= 1'b0;
      frame_valid <= 1'b0;
      duty_meas   <= '0;
      led_idx     <= '0;
      idx_changed <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      idx_nxt     <= idx_now;
      frame_valid <= frame_end;
      idx_changed <= frame_end && first_done && (idx_now != led_idx);
      if (frame_end) begin
        win_cnt    <= '0;
        acc        <= '0;
        multi_nxt  <= 1'b0;
        duty_meas  <= duty_now;
        led_idx    <= idx_now;
        err_multi  <= multi_nxt | sample_multi;
        first_done <= 1'b1;
      end else begin
        win_cnt   <= win_cnt + 1'b1;
        acc       <= duty_now;
        multi_nxt <= multi_nxt | sample_multi;
      end
    end
  end

  // The trend FSM sees the frame's final duty on the same edge the outputs register.
  led_trend_fsm #(
    .HOLD_FRAMES(HOLD_FRAMES),
    .CNT_W      (CNT_W)
  ) u_trend (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_valid_int(frame_end),
    .duty_meas      (duty_now),
    .trend          (trend)
  );

endmodule

// File: tb/tb_led_pwm_monitor.sv
// Randomised self-checking bench for led_pwm_monitor with a frame-level
// reference model built from per-frame sample lists.
module tb_led_pwm_monitor;

  localparam int P    = 6;
  localparam int HOLD = 4;
  localparam int CW   = $clog2(P + 1);
  localparam logic [1:0] T_FLAT = 2'b00;
  localparam logic [1:0] T_RISE = 2'b01;
  localparam logic [1:0] T_FALL = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    led_in = 8'h00;
  logic          frame_valid, idx_changed, err_multi;
  logic [CW-1:0] duty_meas;
  logic [2:0]    led_idx;
  logic [1:0]    trend;

  logic [7:0] samples[$];
  int         exp_duty, exp_idx, m_prev, m_eq;
  bit         exp_fv, exp_changed, exp_err, m_seen;
  logic [1:0] exp_trend;
  int         n_checks = 0;
  int         n_pass = 0;

  led_pwm_monitor #(.PERIOD(P), .HOLD_FRAMES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .frame_valid(frame_valid),
    .duty_meas  (duty_meas),
    .led_idx    (led_idx),
    .idx_changed(idx_changed),
    .err_multi  (err_multi),
    .trend      (trend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  task automatic model_reset();
    samples.delete();
    exp_duty = 0; exp_idx = 0; m_prev = 0; m_eq = 0;
    exp_fv = 0; exp_changed = 0; exp_err = 0; m_seen = 0;
    exp_trend = T_FLAT;
  endtask

  // Frame-level model: once P samples are collected, derive everything from the list.
  task automatic model_step(input logic [7:0] v);
    int d, ni;
    bit e;
    samples.push_back(v);
    exp_fv = 0;
    exp_changed = 0;
    if (samples.size() == P) begin
      d = 0; e = 0; ni = exp_idx;
      foreach (samples[k]) begin
        if (samples[k] != 0) d++;
        if ($countones(samples[k]) > 1) e = 1;
        else if ($countones(samples[k]) == 1)
          for (int b = 0; b < 8; b++) if (samples[k][b]) ni = b;
      end
      exp_changed = m_seen && (ni != exp_idx);
      if (m_seen) begin
        if (d > m_prev) begin exp_trend = T_RISE; m_eq = 0; end
        else if (d < m_prev) begin exp_trend = T_FALL; m_eq = 0; end
        else begin
          if (m_eq < HOLD) m_eq++;
          if (m_eq == HOLD) exp_trend = T_FLAT;
        end
      end
      m_prev = d; exp_idx = ni; exp_duty = d; exp_err = e;
      exp_fv = 1; m_seen = 1;
      samples.delete();
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply_stimulus(input logic [7:0] v);
    led_in = v;
    @(posedge clk);
    if (rst_n) model_step(v);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      led_in = (i % 2 == 0) ? 8'h04 : 8'h13;
      n_checks++;
      if ({frame_valid, duty_meas, led_idx, idx_changed, err_multi, trend} !== '0)
        $display("[TB] FAIL reset_hold: outputs=%b required all zero", {frame_valid, duty_meas, led_idx, idx_changed, err_multi, trend});
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= P; i++) begin
      apply_stimulus(8'h00);
      n_checks++;
      if (frame_valid !== (i == P)) $display("[TB] FAIL first_fv cycle %0d: got %b required %b", i, frame_valid, (i == P));
      else n_pass++;
    end
  endtask

  task automatic test_steady();
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < P; c++) apply_stimulus(c < 3 ? 8'h04 : 8'h00);
      n_checks += 5;
      if (frame_valid !== 1'b1) $display("[TB] FAIL steady_fv f%0d: got %b required 1", f, frame_valid); else n_pass++;
      if (duty_meas !== CW'(3) || led_idx !== 3'd2 || err_multi !== 1'b0)
        $display("[TB] FAIL steady_vals f%0d: got duty %0d idx %0d err %b required 3 2 0", f, duty_meas, led_idx, err_multi);
      else n_pass++;
      if (idx_changed !== exp_changed) $display("[TB] FAIL steady_chg f%0d: got %b required %b", f, idx_changed, exp_changed); else n_pass++;
      if (f > 0 && idx_changed !== 1'b0) $display("[TB] FAIL steady_nochg f%0d: got %b required 0", f, idx_changed); else n_pass++;
      if (trend !== exp_trend || (f >= 4 && trend !== T_FLAT))
        $display("[TB] FAIL steady_trend f%0d: got %b required %b", f, trend, exp_trend);
      else n_pass++;
    end
  endtask

  task automatic test_ramp();
    int duties[10] = '{1, 2, 3, 4, 3, 2, 2, 2, 2, 2};
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < P; c++) apply_stimulus(c < duties[f] ? 8'h08 : 8'h00);
      n_checks += 2;
      if (duty_meas !== CW'(duties[f]) || duty_meas !== CW'(exp_duty))
        $display("[TB] FAIL ramp_duty f%0d: got %0d required %0d", f, duty_meas, duties[f]);
      else n_pass++;
      if (trend !== exp_trend) $display("[TB] FAIL ramp_trend f%0d: got %b required %b", f, trend, exp_trend);
      else n_pass++;
      if (f == 1 || f == 4 || f == 8 || f == 9) begin
        n_checks++;
        if (trend !== (f == 1 ? T_RISE : (f == 9 ? T_FLAT : T_FALL)))
          $display("[TB] FAIL ramp_key f%0d: got %b", f, trend);
        else n_pass++;
      end
    end
  endtask

  task automatic test_index_switch();
    logic [7:0] leds[4] = '{8'h08, 8'h08, 8'h10, 8'h00};
    int pulses = 0;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < P; c++) begin
        apply_stimulus(c < 2 ? leds[f] : 8'h00);
        if (idx_changed === 1'b1) pulses++;
      end
      n_checks++;
      if (idx_changed !== (f == 2)) $display("[TB] FAIL idx_chg f%0d: got %b required %b", f, idx_changed, (f == 2));
      else n_pass++;
    end
    n_checks += 2;
    if (pulses != 1) $display("[TB] FAIL idx_pulses: got %0d required 1", pulses); else n_pass++;
    if (led_idx !== 3'd4 || duty_meas !== CW'(0))
      $display("[TB] FAIL dark_frame: got idx %0d duty %0d required 4 0", led_idx, duty_meas);
    else n_pass++;
  endtask

  task automatic test_multi_hot();
    logic [7:0] fr[P] = '{8'h04, 8'h04, 8'h11, 8'h00, 8'h00, 8'h00};
    for (int c = 0; c < P; c++) apply_stimulus(fr[c]);
    n_checks++;
    if (err_multi !== 1'b1 || duty_meas !== CW'(3) || led_idx !== 3'd2)
      $display("[TB] FAIL multi_frame: got err %b duty %0d idx %0d required 1 3 2", err_multi, duty_meas, led_idx);
    else n_pass++;
    for (int c = 0; c < P; c++) apply_stimulus(c < 2 ? 8'h04 : 8'h00);
    n_checks++;
    if (err_multi !== 1'b0 || duty_meas !== CW'(2))
      $display("[TB] FAIL multi_clear: got err %b duty %0d required 0 2", err_multi, duty_meas);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] mask, v;
    int d, a, b;
    mask = 8'h01;
    for (int f = 0; f < 20; f++) begin
      d = $urandom_range(0, P);
      if ($urandom_range(0, 2) == 0) mask = 8'h01 << $urandom_range(0, 7);
      for (int c = 0; c < P; c++) begin
        v = (c < d) ? mask : 8'h00;
        if ($urandom_range(0, 11) == 0) begin
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          v = (8'h01 << a) | (8'h01 << b);
        end
        apply_stimulus(v);
        n_checks += 4;
        if (frame_valid !== exp_fv || idx_changed !== exp_changed)
          $display("[TB] FAIL rand_pulse f%0d c%0d: got fv %b chg %b required %b %b", f, c, frame_valid, idx_changed, exp_fv, exp_changed);
        else n_pass++;
        if (duty_meas !== CW'(exp_duty)) $display("[TB] FAIL rand_duty f%0d c%0d: got %0d required %0d", f, c, duty_meas, exp_duty); else n_pass++;
        if (led_idx !== 3'(exp_idx) || err_multi !== exp_err)
          $display("[TB] FAIL rand_idx_err f%0d c%0d: got %0d %b required %0d %b", f, c, led_idx, err_multi, exp_idx, exp_err);
        else n_pass++;
        if (trend !== exp_trend) $display("[TB] FAIL rand_trend f%0d c%0d: got %b required %b", f, c, trend, exp_trend); else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < P; c++) apply_stimulus(c < 4 ? 8'h40 : 8'h00);
    n_checks++;
    if (duty_meas !== CW'(4) || led_idx !== 3'd6)
      $display("[TB] FAIL pre_reset: got duty %0d idx %0d required 4 6", duty_meas, led_idx);
    else n_pass++;
    for (int c = 0; c < 3; c++) apply_stimulus(8'h40);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({frame_valid, duty_meas, led_idx, idx_changed, err_multi, trend} !== '0)
      $display("[TB] FAIL mid_reset_clear: outputs=%b required all zero", {frame_valid, duty_meas, led_idx, idx_changed, err_multi, trend});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (frame_valid !== 1'b0) $display("[TB] FAIL mid_reset_nofv: got %b required 0", frame_valid); else n_pass++;
    rst_n = 1'b1;
    for (int i = 1; i <= P; i++) begin
      apply_stimulus(8'h40);
      n_checks++;
      if (frame_valid !== (i == P)) $display("[TB] FAIL post_reset_fv cycle %0d: got %b required %b", i, frame_valid, (i == P));
      else n_pass++;
    end
    n_checks++;
    if (duty_meas !== CW'(6) || led_idx !== 3'd6 || idx_changed !== 1'b0)
      $display("[TB] FAIL post_reset_frame: got duty %0d idx %0d chg %b required 6 6 0", duty_meas, led_idx, idx_changed);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    test_reset();
    test_steady();
    test_ramp();
    test_index_switch();
    test_multi_hot();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
